// File: rtl/vga_pkg.sv
// vga_pkg: shared geometry, fetch FSM encoding and framebuffer line-base helper
//   H_ACTIVE  visible pixels per line (line-buffer depth)
//   V_ACTIVE  visible lines per frame
//   ADDR_W    framebuffer word address width
//   FB_BASE   framebuffer base word address
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 19;
    localparam logic [ADDR_W-1:0] FB_BASE = '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // t*640 as t*512 + t*128
    function automatic logic [ADDR_W-1:0] line_base(input logic [9:0] t);
        logic [ADDR_W-1:0] w_t;
        w_t = ADDR_W'(t);
        return FB_BASE + (w_t << 9) + (w_t << 7);
    endfunction
endpackage

// File: rtl/vga_line_buf.sv
// vga_line_buf: 2 x H_ACTIVE x 12 ping-pong line RAM, sync write, async read
//   i_clk      write clock
//   i_we       write enable
//   i_wsel     bank written
//   i_waddr    write column
//   i_wdata    write pixel
//   i_rsel     bank read
//   i_raddr    read column (caller masks columns >= H_ACTIVE)
//   o_rdata    read pixel, combinational
module vga_line_buf
    import vga_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_we,
    input  logic        i_wsel,
    input  logic [9:0]  i_waddr,
    input  logic [11:0] i_wdata,
    input  logic        i_rsel,
    input  logic [9:0]  i_raddr,
    output logic [11:0] o_rdata
);
    logic [11:0] r_mem [2][H_ACTIVE];

    always_ff @(posedge i_clk)
        if (i_we) r_mem[i_wsel][i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_rsel][i_raddr];
endmodule

// File: rtl/vga_line_prefetch.sv
// vga_line_prefetch: ping-pong line prefetcher feeding the VGA driver's pixel input
//   i_clk          pixel clock
//   i_rst_n        asynchronous reset, active low
//   i_row_addr     driver row (1023 = line before row 0)
//   i_col_addr     driver column
//   o_pix          12-bit RGB pixel, combinational from i_col_addr
//   o_mem_req      fetch request, held with o_mem_addr until i_mem_ack
//   o_mem_addr     framebuffer word address
//   i_mem_ack      request accepted, i_mem_rdata valid this cycle
//   i_mem_rdata    fetched pixel
//   o_underrun     sticky: a fill was incomplete at its swap
//   i_underrun_clr synchronous clear of o_underrun (a new underrun wins)
module vga_line_prefetch
    import vga_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [9:0]        i_row_addr,
    input  logic [9:0]        i_col_addr,
    output logic [11:0]       o_pix,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [11:0]       i_mem_rdata,
    output logic              o_underrun,
    input  logic              i_underrun_clr
);
    logic [1:0]  r_state;
    logic [9:0]  r_fcol;
    logic [9:0]  r_tgt;
    logic [9:0]  r_row_prev;
    logic        r_disp_sel;
    logic [1:0]  r_buf_valid;
    logic        r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic        r_underrun;
    logic [11:0] w_rdata;

    logic       w_new_line;
    logic [9:0] w_t;
    logic [9:0] w_launch_t;
    logic       w_launch;
    logic       w_launch_ok;
    logic       w_we;

    assign w_new_line = i_row_addr != r_row_prev;
    assign w_t        = i_row_addr + 10'd1;
    // A drain exiting on a quiet cycle fetches the latched target; otherwise the fresh one.
    assign w_launch_t  = (r_state == S_DRAIN && !w_new_line) ? r_tgt : w_t;
    // IDLE starts on a row change, FETCH restarts when the row change coincides with an
    // ack (that beat is discarded), DRAIN leaves on the ack that closes the stale request.
    assign w_launch    = (r_state == S_IDLE)  ? w_new_line :
                         (r_state == S_FETCH) ? (w_new_line && i_mem_ack) :
                         i_mem_ack;
    assign w_launch_ok = w_launch_t < 10'(V_ACTIVE);
    assign w_we        = r_state == S_FETCH && i_mem_ack && !w_new_line;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_fcol      <= '0;
            r_tgt       <= '0;
            r_row_prev  <= 10'h3FE;
            r_disp_sel  <= 1'b0;
            r_buf_valid <= 2'b00;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_row_prev <= i_row_addr;
            if (w_new_line) begin
                r_disp_sel              <= ~r_disp_sel;
                r_buf_valid[r_disp_sel] <= 1'b0;
            end
            if (w_new_line && r_state != S_IDLE) r_underrun <= 1'b1;
            else if (i_underrun_clr)             r_underrun <= 1'b0;
            if (w_launch) begin
                r_state   <= w_launch_ok ? S_FETCH : S_IDLE;
                r_mem_req <= w_launch_ok;
                r_fcol    <= '0;
                if (w_launch_ok) r_mem_addr <= line_base(w_launch_t);
            end else if (w_new_line && r_state != S_IDLE) begin
                // The outstanding request must stay stable until acked.
                r_state <= S_DRAIN;
                r_tgt   <= w_t;
            end else if (w_we) begin
                if (r_fcol == 10'(H_ACTIVE - 1)) begin
                    r_buf_valid[~r_disp_sel] <= 1'b1;
                    r_mem_req                <= 1'b0;
                    r_state                  <= S_IDLE;
                end else begin
                    r_fcol     <= r_fcol + 10'd1;
                    r_mem_addr <= r_mem_addr + ADDR_W'(1);
                end
            end
        end
    end

    vga_line_buf u_buf (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_wsel  (~r_disp_sel),
        .i_waddr (r_fcol),
        .i_wdata (i_mem_rdata),
        .i_rsel  (r_disp_sel),
        .i_raddr (i_col_addr),
        .o_rdata (w_rdata)
    );

    assign o_pix      = (r_buf_valid[r_disp_sel] && i_col_addr < 10'(H_ACTIVE)) ? w_rdata : 12'h000;
    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;
    assign o_underrun = r_underrun;
endmodule

// File: tb/tb_vga_line_prefetch.sv
// tb_vga_line_prefetch: directed self-checking bench for vga_line_prefetch
module tb_vga_line_prefetch;
    import vga_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [9:0]        row = 10'd1023;
    logic [9:0]        col = 10'd0;
    logic [11:0]       pix;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [11:0]       rdata;
    logic              underrun;
    logic              clr = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              phase = 1'b0;
    int                n_chk = 0;
    int                n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) phase <= ~phase;

    // mode 0: never ack, 1: ack every cycle, 2: ack every other cycle
    assign ack   = (mode == 2'd1) || (mode == 2'd2 && phase);
    assign rdata = addr[11:0];

    vga_line_prefetch dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_row_addr     (row),
        .i_col_addr     (col),
        .o_pix          (pix),
        .o_mem_req      (req),
        .o_mem_addr     (addr),
        .i_mem_ack      (ack),
        .i_mem_rdata    (rdata),
        .o_underrun     (underrun),
        .i_underrun_clr (clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        step(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req",      32'(req),      32'h0);
        chk("rst_underrun", 32'(underrun), 32'h0);
        chk("rst_pix",      32'(pix),      32'h0);
        chk("rst_addr",     32'(addr),     32'h0);

        mode = 2'd1; row = 10'd1023; col = 10'd5;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("line0_req",  32'(req),  32'h1);
        chk("line0_addr", 32'(addr), 32'h0);
        step(700);
        chk("line0_done", 32'(req), 32'h0);
        row = 10'd0;
        step(1);
        chk("row0_col5", 32'(pix),  32'h005);
        chk("line1_addr", 32'(addr), 32'h280);
        col = 10'd639; #1;
        chk("row0_col639", 32'(pix), 32'h27F);
        col = 10'd640; #1;
        chk("row0_col640", 32'(pix), 32'h000);
        col = 10'd1023; #1;
        chk("row0_col1023", 32'(pix), 32'h000);
        step(700);
        row = 10'd1; col = 10'd3;
        step(1);
        chk("row1_col3",    32'(pix),      32'h283);
        chk("row1_underrun", 32'(underrun), 32'h0);
        chk("line2_addr",   32'(addr),     32'h500);

        mode = 2'd2;
        step(800);
        row = 10'd2; col = 10'd0;
        step(1);
        chk("slow_underrun", 32'(underrun), 32'h1);
        chk("slow_pix0",     32'(pix),      32'h000);
        col = 10'd300; #1;
        chk("slow_pix300",   32'(pix),      32'h000);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("slow_clr", 32'(underrun), 32'h0);

        rst_n = 1'b0; mode = 2'd0; row = 10'd1023; col = 10'd5;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("invalid_pix", 32'(pix),  32'h000);
        chk("drain_req0",  32'(req),  32'h1);
        chk("drain_addr0", 32'(addr), 32'h0);
        row = 10'd0;
        step(1);
        chk("drain_underrun", 32'(underrun), 32'h1);
        chk("drain_addr1",    32'(addr),     32'h0);
        chk("drain_req1",     32'(req),      32'h1);
        step(3);
        chk("drain_hold", 32'(addr), 32'h0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("drain_clr", 32'(underrun), 32'h0);
        row = 10'd1; clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("set_wins",    32'(underrun), 32'h1);
        chk("drain_addr2", 32'(addr),     32'h0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("set_wins_clr", 32'(underrun), 32'h0);
        mode = 2'd1;
        step(1);
        mode = 2'd0;
        chk("drain_exit_addr", 32'(addr), 32'h500);
        chk("drain_exit_req",  32'(req),  32'h1);
        step(3);
        chk("fetch_hold", 32'(addr), 32'h500);
        mode = 2'd1;
        step(10);
        chk("fetch_adv", 32'(addr), 32'h50A);
        row = 10'd2;
        step(1);
        chk("restart_addr", 32'(addr), 32'h780);

        row = 10'd478;
        step(1);
        chk("line479_addr", 32'(addr), 32'h4AD80);
        chk("line479_req",  32'(req),  32'h1);
        step(700);
        row = 10'd479;
        step(1);
        chk("row479_req", 32'(req), 32'h0);
        for (int r = 480; r <= 1022; r++) begin
            row = 10'(r);
            step(1);
            chk("blank_req", 32'(req), 32'h0);
        end
        row = 10'd1023;
        step(1);
        chk("wrap_req",  32'(req),  32'h1);
        chk("wrap_addr", 32'(addr), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
